iir_decim_out: RTL
==================

# iir_decim_out

Output stage that sits directly downstream of the `iir_filter` chain and consumes its filtered sample stream. It counts `en` sample strobes and keeps one sample in `R`. Each kept sample is shifted right with round-half-up, saturated to a narrower word and pushed into a small FIFO. The FIFO is drained through a valid/ready handshake toward the DAC/packetiser. Overruns are flagged, never stalled, because the IIR stage has no backpressure.

## Interface
- `w`, 32: input word width; matches the IIR `w`. Signed two's complement, `FW` fractional bits.
- `FW`, 16: input fractional bits. Informational only; scaling is set by `SH`.
- `OW`, 16: output word width (signed).
- `SH`, 8: arithmetic right shift applied before saturation; 0 ≤ `SH` < `w`.
- `R`, 8: decimation ratio, ≥ 1.
- `DEPTH`, 4: FIFO entries, power of two, ≥ 2.

Ports (name, direction, width, meaning):
- `clk` in 1: sole clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset; has priority over every other input.
- `en` in 1: input sample strobe; same strobe that drives the IIR stage.
- `in` in `w`: filtered sample from the IIR output; valid when `en`=1.
- `out_data` out `OW`: FIFO head sample.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts the head this cycle.
- `sat` out 1: one-cycle pulse when a captured sample was clipped.
- `overflow` out 1: sticky; set when a sample is dropped on a full FIFO; cleared only by `rst`.

## Operation
- Phase counter `ph`, range 0..R-1.
  - Increments on each `en`; wraps R-1→0.
  - Holds when `en`=0.
- Capture: when `en`=1 and `ph`=R-1, `in` is processed into stage register `s_data` and `s_vld` is set for one cycle.
  - For `R`=1, every `en` captures.
- Arithmetic, computed in `w`+1 bits:
  - `t` = `in` + 2^(SH-1) when `SH`>0; `t` = `in` when `SH`=0.
  - `t` is then shifted right arithmetically by `SH`.
  - Result is clamped to [-2^(OW-1), 2^(OW-1)-1].
  - If clamping changed the value, `sat` pulses in the same cycle that `s_vld` is high.
  - Rounding is half-up toward +inf: -1.5 LSB → -1; -1.51 → -2.
- FIFO push, when `s_vld`=1:
  - Write if not full, or if full and a pop occurs in the same cycle (pop frees the slot).
  - Otherwise drop the sample and set `overflow`.
  - FIFO contents are never overwritten.
- FIFO pop: when `out_valid`=1 and `out_ready`=1 the head advances.
  - `out_ready` while empty has no effect.
- FIFO is first-word-fallthrough: `out_data` shows the head combinationally from storage whenever `out_valid`=1.
  - `out_data` is held stable while `out_valid`=1 and `out_ready`=0.
- Pointers are `log2(DEPTH)`+1 bits.
  - Full when the MSBs differ and the rest are equal.
  - Empty when the pointers are equal.
  - Wrap-around is natural.
- Simultaneous push and pop when empty: the pushed sample appears next cycle; the pop is ignored because `out_valid` was 0.

## Timing
- Reset values:
  - `ph`=0, `s_vld`=0, FIFO empty.
  - `out_valid`=0, `out_data`=0, `sat`=0, `overflow`=0.
- Latency:
  - Capture edge E0 loads `s_data`.
  - Edge E1 writes the FIFO.
  - `out_valid` is high in the cycle after E1: 2 clocks from the capture edge to visibility.
- Throughput: one push and one pop per clock.
- Back-to-back captures are possible only when `R`=1 with `en` held high.
- `rst` asserted mid-operation:
  - Next cycle: FIFO empty, `s_vld` cleared, in-flight sample discarded, `ph`=0.
  - The first capture after reset is the R-th `en` following deassertion.

## Test plan
Common setup: `w`=32, `OW`=16, `SH`=8, `R`=4, `DEPTH`=4; `out_ready`=1 unless stated.
- **Decimation:** `en`=1 every cycle, `in`=k·256 for k=0..11 → `out_data` sequence 3, 7, 11; each appears 2 clocks after its capture edge; `sat`=0 throughout.
- **Rounding:** captured `in` = 384, 383, -384, -385 → `out_data` = 2, 1, -1, -2.
- **Saturation:** captured `in` = 0x00800000 → 32767 with `sat` pulse; captured `in` = 0x80000000 → -32768 with `sat` pulse; captured `in` = 0x007FFF00 → 32767 with no `sat`.
- **Overrun:** `out_ready`=0, six captures of 1..6 (·256) → `overflow`=1 after the 5th capture; then `out_ready`=1 drains exactly 1, 2, 3, 4, and `out_valid` falls after the 4th.
- **Full with simultaneous pop:** fill 4 entries; assert `out_ready` in the same cycle a 5th `s_vld` occurs → 5th sample accepted, `overflow` stays 0, drain order preserved.
- **Reset mid-stream:** 2 entries queued, `ph`=2, sample in `s_data`; pulse `rst` one cycle → `out_valid`=0 and `overflow`=0 next cycle; the next output follows the 4th `en` after reset.

Source files
------------

// File: rtl/iir_decim_out.sv
// Decimating output stage for the iir_filter chain.
// Keeps one sample in R, rounds, shifts, saturates, and queues the result in a first-word-fallthrough FIFO.
module iir_decim_out #(
  parameter int unsigned w     = 32,
  parameter int unsigned FW    = 16,
  parameter int unsigned OW    = 16,
  parameter int unsigned SH    = 8,
  parameter int unsigned R     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [w-1:0]  in,
  output logic [OW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sat,
  output logic          overflow
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PW   = AW + 1;
  localparam int unsigned PH_W = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned XW   = w + 1;

  // Half-LSB rounding constant at the post-shift scale; zero when no shift is applied.
  localparam logic [XW-1:0] RND =
    (SH == 0) ? '0 : (XW'(1) << ((SH == 0) ? 0 : (SH - 1)));
  localparam logic signed [XW-1:0] HI = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] LO = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  if (SH >= w || R < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FW > w || OW > w)
  begin : g_param_chk
    $error("iir_decim_out: illegal parameterisation");
  end

  logic [PH_W-1:0]       ph;
  logic                  s_vld;
  logic [OW-1:0]         s_data;
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [OW-1:0]         mem [DEPTH];

  logic                  last_ph_c;
  logic                  capture_c;
  logic signed [XW-1:0]  t_c;
  logic signed [XW-1:0]  sh_c;
  logic [OW-1:0]         q_c;
  logic                  clip_c;
  logic                  full_c;
  logic                  pop_c;
  logic                  push_c;

  // Decimation phase and capture decision.
  always_comb begin
    last_ph_c = (ph == PH_W'(R - 1));
    capture_c = en && last_ph_c;
  end

  // Round half-up, arithmetic shift, clamp to the output range.
  always_comb begin
    t_c    = $signed({in[w-1], in}) + $signed(RND);
    sh_c   = t_c >>> SH;
    q_c    = sh_c[OW-1:0];
    clip_c = 1'b0;
    if (sh_c > HI) begin
      q_c    = HI[OW-1:0];
      clip_c = 1'b1;
    end else if (sh_c < LO) begin
      q_c    = LO[OW-1:0];
      clip_c = 1'b1;
    end
  end

  // FIFO status; a pop in the same cycle frees the slot for a push on a full FIFO.
  always_comb begin
    full_c    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    out_valid = (wptr != rptr);
    pop_c     = out_valid && out_ready;
    push_c    = s_vld && (!full_c || pop_c);
    out_data  = out_valid ? mem[rptr[AW-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph       <= '0;
      s_vld    <= 1'b0;
      s_data   <= '0;
      sat      <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (en) begin
        ph <= last_ph_c ? '0 : ph + PH_W'(1);
      end
      s_vld <= capture_c;
      sat   <= capture_c && clip_c;
      if (capture_c) begin
        s_data <= q_c;
      end
      if (push_c) begin
        wptr <= wptr + PW'(1);
      end
      if (pop_c) begin
        rptr <= rptr + PW'(1);
      end
      // Dropped samples are flagged, never stalled: the IIR stage has no backpressure.
      if (s_vld && !push_c) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset; out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wptr[AW-1:0]] <= s_data;
    end
  end

endmodule
